regfile_master: RTL and testbench

- Initiator that drives the 4-entry masked-write register file ports: r1, r2, w1, mask, w in; v1, v2 out.
- Accepts one command at a time over a valid/ready handshake and sequences the register-file read and/or write cycles.
- Returns results over a valid/ready response channel.
- Sits between the CPU decode/execute control and the register file; it is the only agent driving the register-file inputs.

---
 rtl/regfile_master_if.sv | 30 +++
 rtl/regfile_master.sv | 188 ++++++++++++++++++
 tb/tb_regfile_master.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_master_if.sv
// Command/response bus between the CPU control and regfile_master.
// The master modport is the CPU side; the slave modport is regfile_master.
interface regfile_master_if #(
  parameter int N = 32,
  parameter int M = 2
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [M-1:0] cmd_rs1;
  logic [M-1:0] cmd_rs2;
  logic [M-1:0] cmd_rd;
  logic [N-1:0] cmd_wdata;
  logic [N-1:0] cmd_wmask;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_d1;
  logic [N-1:0] resp_d2;
  logic         resp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wdata, cmd_wmask, resp_ready,
    input  cmd_ready, resp_valid, resp_d1, resp_d2, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, cmd_wdata, cmd_wmask, resp_ready,
    output cmd_ready, resp_valid, resp_d1, resp_d2, resp_err
  );
endinterface

// File: rtl/regfile_master.sv
// regfile_master: sequences read / write / add commands onto a 4-entry
// masked-write register file and returns results on a response channel.
// Optional build macro: REGFILE_MASTER_READBACK_EN adds a readback check
// after every write (VWAIT state) and flags a mismatch on resp_err.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command
// ISSUE | read indices presented, register file samples them
// WAIT  | read data valid; capture it, form the ADD sum
// WRITE | the only cycle with a nonzero rf_mask
// VWAIT | (readback build) compare post-write value against written data
// RESP  | response held until resp_ready
module regfile_master #(
  parameter int N = 32,
  parameter int M = 2
) (
  input  logic            clk,
  input  logic            rst,
  regfile_master_if.slave bus,
  output logic [M-1:0]    rf_r1,
  output logic [M-1:0]    rf_r2,
  output logic [M-1:0]    rf_w1,
  output logic [N-1:0]    rf_mask,
  output logic [N-1:0]    rf_w,
  input  logic [N-1:0]    rf_v1,
  input  logic [N-1:0]    rf_v2
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

`ifdef REGFILE_MASTER_READBACK_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, VWAIT, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;
`endif

  state_t       state, state_nxt;
  logic         cmd_ready_q, cmd_ready_nxt;
  logic         resp_valid_q, resp_valid_nxt;
  logic [N-1:0] resp_d1_q, resp_d1_nxt;
  logic [N-1:0] resp_d2_q, resp_d2_nxt;
  logic         resp_err_q, resp_err_nxt;
  logic [M-1:0] rf_r1_nxt, rf_r2_nxt, rf_w1_nxt;
  logic [N-1:0] rf_mask_nxt, rf_w_nxt;
  logic [1:0]   op_q, op_nxt;
  logic [M-1:0] rd_q, rd_nxt;
  logic [N-1:0] mask_q, mask_nxt;

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_d1    = resp_d1_q;
  assign bus.resp_d2    = resp_d2_q;
  assign bus.resp_err   = resp_err_q;

  // Next-state and next-output logic; every output is the registered copy of these.
  always_comb begin
    state_nxt      = state;
    resp_valid_nxt = resp_valid_q;
    resp_d1_nxt    = resp_d1_q;
    resp_d2_nxt    = resp_d2_q;
    resp_err_nxt   = resp_err_q;
    rf_r1_nxt      = rf_r1;
    rf_r2_nxt      = rf_r2;
    rf_w1_nxt      = rf_w1;
    rf_w_nxt       = rf_w;
    rf_mask_nxt    = '0;
    op_nxt         = op_q;
    rd_nxt         = rd_q;
    mask_nxt       = mask_q;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          op_nxt       = bus.cmd_op;
          rd_nxt       = bus.cmd_rd;
          mask_nxt     = bus.cmd_wmask;
          resp_d1_nxt  = '0;
          resp_d2_nxt  = '0;
          resp_err_nxt = 1'b0;
          case (bus.cmd_op)
            OP_READ, OP_ADD: begin
              rf_r1_nxt = bus.cmd_rs1;
              rf_r2_nxt = bus.cmd_rs2;
              state_nxt = ISSUE;
            end
            OP_WRITE: begin
              rf_w1_nxt   = bus.cmd_rd;
              rf_w_nxt    = bus.cmd_wdata;
              rf_mask_nxt = bus.cmd_wmask;
`ifdef REGFILE_MASTER_READBACK_EN
              rf_r1_nxt   = bus.cmd_rd;
`endif
              state_nxt   = WRITE;
            end
            default: begin
              resp_err_nxt   = 1'b1;
              resp_valid_nxt = 1'b1;
              state_nxt      = RESP;
            end
          endcase
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        resp_d1_nxt = rf_v1;
        resp_d2_nxt = rf_v2;
        if (op_q == OP_ADD) begin
          rf_w1_nxt   = rd_q;
          rf_w_nxt    = rf_v1 + rf_v2;
          rf_mask_nxt = mask_q;
`ifdef REGFILE_MASTER_READBACK_EN
          rf_r1_nxt   = rd_q;
`endif
          state_nxt   = WRITE;
        end else begin
          resp_valid_nxt = 1'b1;
          state_nxt      = RESP;
        end
      end
      WRITE: begin
`ifdef REGFILE_MASTER_READBACK_EN
        state_nxt = VWAIT;
`else
        resp_valid_nxt = 1'b1;
        state_nxt      = RESP;
`endif
      end
`ifdef REGFILE_MASTER_READBACK_EN
      VWAIT: begin
        // rf_w still holds the written data; only masked bits must match.
        if (((rf_v1 ^ rf_w) & mask_q) != '0) resp_err_nxt = 1'b1;
        resp_valid_nxt = 1'b1;
        state_nxt      = RESP;
      end
`endif
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    cmd_ready_nxt = (state_nxt == IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Output and command registers; async reset clears rf_mask at once so an aborted write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_d1_q    <= '0;
      resp_d2_q    <= '0;
      resp_err_q   <= 1'b0;
      rf_r1        <= '0;
      rf_r2        <= '0;
      rf_w1        <= '0;
      rf_mask      <= '0;
      rf_w         <= '0;
      op_q         <= '0;
      rd_q         <= '0;
      mask_q       <= '0;
    end else begin
      cmd_ready_q  <= cmd_ready_nxt;
      resp_valid_q <= resp_valid_nxt;
      resp_d1_q    <= resp_d1_nxt;
      resp_d2_q    <= resp_d2_nxt;
      resp_err_q   <= resp_err_nxt;
      rf_r1        <= rf_r1_nxt;
      rf_r2        <= rf_r2_nxt;
      rf_w1        <= rf_w1_nxt;
      rf_mask      <= rf_mask_nxt;
      rf_w         <= rf_w_nxt;
      op_q         <= op_nxt;
      rd_q         <= rd_nxt;
      mask_q       <= mask_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_master.sv
// Bench for regfile_master: a behavioural 4-entry register file sits on the
// rf_* ports, and an array-level reference model predicts every response.
module tb_regfile_master;

`ifdef REGFILE_MASTER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rf_r1, rf_r2, rf_w1;
  logic [31:0] rf_mask, rf_w, rf_v1, rf_v2;

  logic [31:0] rf_mem [4] = '{default: 32'h0};
  logic [31:0] rf_tmp [4];
  logic [31:0] ref_regs [4] = '{default: 32'h0};
  int          mask_total = 0;
  int          errors = 0;
  int          checks = 0;

  regfile_master_if #(.N(32), .M(2)) bus ();

  regfile_master #(.N(32), .M(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_w1(rf_w1), .rf_mask(rf_mask), .rf_w(rf_w),
    .rf_v1(rf_v1), .rf_v2(rf_v2)
  );

  always #5 clk = ~clk;

  // Register file: masked write every edge, registered read with write-through.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) rf_tmp[i] = rf_mem[i];
    rf_tmp[rf_w1] = (rf_mem[rf_w1] & ~rf_mask) | (rf_w & rf_mask);
    for (int i = 0; i < 4; i++) rf_mem[i] <= rf_tmp[i];
    rf_v1 <= rf_tmp[rf_r1];
    rf_v2 <= rf_tmp[rf_r2];
  end

  always @(posedge clk) if (rf_mask != 32'h0) mask_total <= mask_total + 1;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [31:0] m);
    return (old & ~m) | (data & m);
  endfunction

  function automatic void predict(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                                  input logic [31:0] wmask, output logic [31:0] d1, output logic [31:0] d2,
                                  output logic err, output int lat, output int mc);
    d1 = 32'h0; d2 = 32'h0; err = 1'b0; mc = (wmask != 32'h0) ? 1 : 0;
    case (op)
      2'd0: begin d1 = ref_regs[rs1]; d2 = ref_regs[rs2]; lat = 3; mc = 0; end
      2'd1: lat = 2 + RB;
      2'd2: begin d1 = ref_regs[rs1]; d2 = ref_regs[rs2]; lat = 4 + RB; end
      default: begin err = 1'b1; lat = 1; mc = 0; end
    endcase
  endfunction

  function automatic void ref_update(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic [1:0] rd, input logic [31:0] wdata, input logic [31:0] wmask);
    logic [31:0] sum;
    sum = ref_regs[rs1] + ref_regs[rs2];
    if (op == 2'd1) ref_regs[rd] = merge(ref_regs[rd], wdata, wmask);
    if (op == 2'd2) ref_regs[rd] = merge(ref_regs[rd], sum, wmask);
  endfunction

  // Drive one command, measure accept-to-response latency, consume the response.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] rs1, input logic [1:0] rs2, input logic [1:0] rd,
                        input logic [31:0] wdata, input logic [31:0] wmask, input int hold,
                        output logic [31:0] d1, output logic [31:0] d2, output logic err,
                        output int lat, output int mc);
    int m0, wt;
    @(negedge clk);
    m0 = mask_total;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
    bus.cmd_rd = rd; bus.cmd_wdata = wdata; bus.cmd_wmask = wmask;
    wt = 0;
    while (!bus.cmd_ready && wt < 20) begin @(negedge clk); wt++; end
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (wt >= 20) lat = -1;
    d1 = bus.resp_d1; d2 = bus.resp_d2; err = bus.resp_err;
    if (bus.resp_valid) begin
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.resp_ready = 1'b0;
    end
    mc = mask_total - m0;
    ref_update(op, rs1, rs2, rd, wdata, wmask);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_flags: got valid=%b err=%b expected 0 0", bus.resp_valid, bus.resp_err); end
    checks++; if (bus.resp_d1 !== 32'h0 || bus.resp_d2 !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h %h expected 0 0", bus.resp_d1, bus.resp_d2); end
    checks++; if (rf_mask !== 32'h0 || rf_w !== 32'h0) begin errors++; $display("FAIL reset_rf_mask_w: got %h %h expected 0 0", rf_mask, rf_w); end
    checks++; if (rf_r1 !== 2'd0 || rf_r2 !== 2'd0 || rf_w1 !== 2'd0) begin errors++; $display("FAIL reset_rf_idx: got %0d %0d %0d expected 0 0 0", rf_r1, rf_r2, rf_w1); end
    rst = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] d1, d2; logic err; int lat, mc;
    do_cmd(2'd1, 2'd0, 2'd0, 2'd2, 32'hDEADBEEF, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    checks++; if (lat !== 2 + RB) begin errors++; $display("FAIL write_latency: got %0d expected %0d", lat, 2 + RB); end
    checks++; if (d1 !== 32'h0 || d2 !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL write_resp: got %h %h err=%b expected 0 0 err=0", d1, d2, err); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL write_mask_cycles: got %0d expected 1", mc); end
    do_cmd(2'd0, 2'd2, 2'd0, 2'd0, 32'h0, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d expected 3", lat); end
    checks++; if (d1 !== 32'hDEADBEEF || d2 !== 32'h0) begin errors++; $display("FAIL read_data: got %h %h expected deadbeef 0", d1, d2); end
    checks++; if (mc !== 0) begin errors++; $display("FAIL read_mask_cycles: got %0d expected 0", mc); end
  endtask

  task automatic test_masked_write;
    logic [31:0] d1, d2; logic err; int lat, mc;
    do_cmd(2'd1, 2'd0, 2'd0, 2'd1, 32'h12345678, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    do_cmd(2'd1, 2'd0, 2'd0, 2'd1, 32'hFFFFFFFF, 32'h0000FF00, 1, d1, d2, err, lat, mc);
    do_cmd(2'd0, 2'd1, 2'd1, 2'd0, 32'h0, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (d1 !== 32'h1234FF78 || d2 !== 32'h1234FF78) begin errors++; $display("FAIL masked_write: got %h %h expected 1234ff78 1234ff78", d1, d2); end
    do_cmd(2'd1, 2'd0, 2'd0, 2'd1, 32'h0BADF00D, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (mc !== 0 || lat !== 2 + RB || err !== 1'b0) begin errors++; $display("FAIL zero_mask_write: got mc=%0d lat=%0d err=%b expected 0 %0d 0", mc, lat, err, 2 + RB); end
    do_cmd(2'd0, 2'd1, 2'd2, 2'd0, 32'h0, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (d1 !== 32'h1234FF78) begin errors++; $display("FAIL zero_mask_unchanged: got %h expected 1234ff78", d1); end
  endtask

  task automatic test_add;
    logic [31:0] d1, d2; logic err; int lat, mc;
    do_cmd(2'd1, 2'd0, 2'd0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    do_cmd(2'd1, 2'd0, 2'd0, 2'd3, 32'h00000002, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    do_cmd(2'd2, 2'd0, 2'd3, 2'd1, 32'h0, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    checks++; if (d1 !== 32'hFFFFFFFF || d2 !== 32'h2 || err !== 1'b0) begin errors++; $display("FAIL add_resp: got %h %h err=%b expected ffffffff 2 err=0", d1, d2, err); end
    checks++; if (lat !== 4 + RB) begin errors++; $display("FAIL add_latency: got %0d expected %0d", lat, 4 + RB); end
    checks++; if (mc !== 1) begin errors++; $display("FAIL add_mask_cycles: got %0d expected 1", mc); end
    do_cmd(2'd0, 2'd1, 2'd0, 2'd0, 32'h0, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (d1 !== 32'h1) begin errors++; $display("FAIL add_carry_dropped: got %h expected 1", d1); end
  endtask

  task automatic test_reserved;
    logic [31:0] d1, d2; logic err; int lat, mc;
    do_cmd(2'd3, 2'd1, 2'd2, 2'd3, 32'h5555AAAA, 32'hFFFFFFFF, 0, d1, d2, err, lat, mc);
    checks++; if (err !== 1'b1 || lat !== 1) begin errors++; $display("FAIL reserved_err_latency: got err=%b lat=%0d expected err=1 lat=1", err, lat); end
    checks++; if (d1 !== 32'h0 || d2 !== 32'h0 || mc !== 0) begin errors++; $display("FAIL reserved_quiet: got %h %h mc=%0d expected 0 0 mc=0", d1, d2, mc); end
  endtask

  task automatic test_resp_hold;
    int wt;
    logic [31:0] e1, e2;
    e1 = ref_regs[2]; e2 = ref_regs[1];
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd0; bus.cmd_rs1 = 2'd2; bus.cmd_rs2 = 2'd1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wt = 0;
    while (!bus.resp_valid && wt < 20) begin @(negedge clk); wt++; end
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL hold_resp_arrives: got valid=%b expected 1", bus.resp_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_d1 !== e1 || bus.resp_d2 !== e2 || bus.cmd_ready !== 1'b0 || rf_mask !== 32'h0) begin
        errors++;
        $display("FAIL hold_stable: got valid=%b d1=%h d2=%h ready=%b mask=%h expected 1 %h %h 0 0",
                 bus.resp_valid, bus.resp_d1, bus.resp_d2, bus.cmd_ready, rf_mask, e1, e2);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got valid=%b ready=%b expected 0 1", bus.resp_valid, bus.cmd_ready); end
  endtask

  task automatic test_reset_abort;
    logic [31:0] keep, d1, d2; logic err; int lat, mc;
    keep = ref_regs[3];
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_rd = 2'd3;
    bus.cmd_wdata = 32'h0000AAAA; bus.cmd_wmask = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    checks++; if (rf_mask !== 32'hFFFFFFFF || rf_w1 !== 2'd3) begin errors++; $display("FAIL abort_write_cycle: got mask=%h w1=%0d expected ffffffff 3", rf_mask, rf_w1); end
    #1 rst = 1'b1;
    #1;
    checks++; if (rf_mask !== 32'h0) begin errors++; $display("FAIL abort_mask_cleared: got %h expected 0", rf_mask); end
    checks++; if (bus.cmd_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got ready=%b valid=%b expected 1 0", bus.cmd_ready, bus.resp_valid); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_cmd(2'd0, 2'd3, 2'd3, 2'd0, 32'h0, 32'h0, 0, d1, d2, err, lat, mc);
    checks++; if (d1 !== keep || lat !== 3) begin errors++; $display("FAIL abort_reg_unchanged: got %h lat=%0d expected %h lat=3", d1, lat, keep); end
  endtask

  task automatic test_random;
    logic [31:0] d1, d2, e1, e2, wd, wm; logic err, eerr; int lat, mc, elat, emc;
    logic [1:0] op, rs1, rs2, rd;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3)); rs1 = 2'($urandom_range(0, 3));
      rs2 = 2'($urandom_range(0, 3)); rd = 2'($urandom_range(0, 3));
      wd = $urandom;
      case ($urandom_range(0, 3))
        0: wm = 32'h0;
        1: wm = 32'hFFFFFFFF;
        default: wm = $urandom;
      endcase
      predict(op, rs1, rs2, wm, e1, e2, eerr, elat, emc);
      do_cmd(op, rs1, rs2, rd, wd, wm, $urandom_range(0, 2), d1, d2, err, lat, mc);
      checks++; if (d1 !== e1 || d2 !== e2) begin errors++; $display("FAIL rand_data[%0d] op=%0d: got %h %h expected %h %h", n, op, d1, d2, e1, e2); end
      checks++; if (err !== eerr) begin errors++; $display("FAIL rand_err[%0d] op=%0d: got %b expected %b", n, op, err, eerr); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d expected %0d", n, op, lat, elat); end
      checks++; if (mc !== emc) begin errors++; $display("FAIL rand_mask_cycles[%0d] op=%0d: got %0d expected %0d", n, op, mc, emc); end
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_rs1 = 2'd0; bus.cmd_rs2 = 2'd0;
    bus.cmd_rd = 2'd0; bus.cmd_wdata = 32'h0; bus.cmd_wmask = 32'h0; bus.resp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_masked_write();
    test_add();
    test_reserved();
    test_resp_hold();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
